// File: rtl/i2c_init_sequencer.sv
// Walks a table of 16-bit codec register words and writes each to one I2C slave.
// Optional NACK retry is enabled by defining I2C_SEQ_RETRY_EN.
module i2c_init_sequencer #(
  parameter int         NUM_REGS    = 10,
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         MAX_RETRIES = 3,
  parameter int         IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             go,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [15:0]      tbl_data,
  output logic             i2c_start,
  output logic             i2c_write,
  output logic             i2c_stop,
  output logic [7:0]       i2c_data,
  input  logic             i2c_done,
  input  logic             i2c_status,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] fail_idx
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_START, S_ADDR, S_HI,
    S_LO, S_STOP, S_NEXT, S_DONE, S_FAIL
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);

  state_t     state;
  state_t     tgt;
  logic       rel;
  logic       nack_flag;
  logic       req_on;
  logic       launch;
  logic       can_retry;
  logic [7:0] tgt_byte;

  assign req_on = i2c_start | i2c_write | i2c_stop;

`ifdef I2C_SEQ_RETRY_EN
  logic [3:0] retry_cnt;
  assign can_retry = retry_cnt < 4'(MAX_RETRIES);
`else
  // Retries disabled: MAX_RETRIES is never negative, so this is constant 0.
  assign can_retry = (MAX_RETRIES < 0);
`endif

  // Decide whether this edge enters (or re-arms) a command state.
  always_comb begin
    launch = 1'b0;
    tgt    = S_START;
    case (state)
      S_LOAD: launch = 1'b1;
      S_START, S_ADDR, S_HI, S_LO, S_STOP: begin
        if (!rel) begin
          // Stale done on entry: raise the request once it drops.
          if (!req_on && !i2c_done) begin
            launch = 1'b1;
            tgt    = state;
          end
        end else if (!i2c_done) begin
          case (state)
            S_START: begin
              launch = 1'b1;
              tgt    = S_ADDR;
            end
            S_ADDR: begin
              launch = 1'b1;
              tgt    = nack_flag ? S_STOP : S_HI;
            end
            S_HI: begin
              launch = 1'b1;
              tgt    = nack_flag ? S_STOP : S_LO;
            end
            S_LO: begin
              launch = 1'b1;
              tgt    = S_STOP;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Byte presented with the request being launched.
  always_comb begin
    case (tgt)
      S_ADDR:  tgt_byte = {DEV_ADDR, 1'b0};
      S_HI:    tgt_byte = tbl_data[15:8];
      S_LO:    tgt_byte = tbl_data[7:0];
      default: tgt_byte = 8'h00;
    endcase
  end

  // Sequencer FSM with registered request and status outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rel       <= 1'b0;
      nack_flag <= 1'b0;
      tbl_idx   <= '0;
      fail_idx  <= '0;
      i2c_start <= 1'b0;
      i2c_write <= 1'b0;
      i2c_stop  <= 1'b0;
      i2c_data  <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
      retry_cnt <= 4'd0;
`endif
    end else if (launch) begin
      state <= tgt;
      rel   <= 1'b0;
      if (!i2c_done) begin
        i2c_start <= (tgt == S_START);
        i2c_write <= (tgt == S_ADDR) || (tgt == S_HI) || (tgt == S_LO);
        i2c_stop  <= (tgt == S_STOP);
        i2c_data  <= tgt_byte;
      end
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (go) begin
            state     <= S_LOAD;
            tbl_idx   <= '0;
            nack_flag <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
            retry_cnt <= 4'd0;
`endif
          end
        end
        S_START, S_ADDR, S_HI, S_LO, S_STOP: begin
          if (!rel && req_on && i2c_done) begin
            i2c_start <= 1'b0;
            i2c_write <= 1'b0;
            i2c_stop  <= 1'b0;
            rel       <= 1'b1;
            if (i2c_status && state inside {S_ADDR, S_HI, S_LO})
              nack_flag <= 1'b1;
          end else if (rel && !i2c_done && state == S_STOP) begin
            if (!nack_flag) begin
              state <= S_NEXT;
            end else if (can_retry) begin
`ifdef I2C_SEQ_RETRY_EN
              retry_cnt <= retry_cnt + 4'd1;
`endif
              nack_flag <= 1'b0;
              state     <= S_LOAD;
            end else begin
              state    <= S_FAIL;
              fail_idx <= tbl_idx;
              error    <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end
        S_NEXT: begin
          if (tbl_idx == LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            tbl_idx   <= tbl_idx + IDX_W'(1);
            nack_flag <= 1'b0;
            state     <= S_LOAD;
`ifdef I2C_SEQ_RETRY_EN
            retry_cnt <= 4'd0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer with a behavioural I2C core model.
// Expectations follow I2C_SEQ_RETRY_EN when it is defined.
module tb_i2c_init_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic [0:0] tbl_idx;
  logic [0:0] fail_idx;
  logic [15:0] tbl_data;
  logic       i2c_start, i2c_write, i2c_stop;
  logic [7:0] i2c_data;
  logic       i2c_done, i2c_status;
  logic       busy, done, error;

  int errors = 0;
  int checks = 0;

  int   mode = 0;
  int   lat = 2;
  int   hold = 0;
  logic stale = 1'b0;

  logic core_done, core_status;
  int   cst, cnt, pos;
  bit   nacked_once, nk;
  logic [9:0] log_q[$];

  int   viol_multi = 0;
  int   viol_stale = 0;
  logic req_prev = 1'b0;
  logic done_prev = 1'b0;

  wire req = i2c_start | i2c_write | i2c_stop;

  always #5 clk = ~clk;

  assign tbl_data   = (tbl_idx == 1'b0) ? 16'h1E00 : 16'h0C12;
  assign i2c_done   = core_done | stale;
  assign i2c_status = core_status;

  i2c_init_sequencer #(
    .NUM_REGS(2), .DEV_ADDR(7'h1A), .MAX_RETRIES(2)
  ) dut (
    .sys_clk(clk), .rst(rst), .go(go),
    .tbl_idx(tbl_idx), .tbl_data(tbl_data),
    .i2c_start(i2c_start), .i2c_write(i2c_write),
    .i2c_stop(i2c_stop), .i2c_data(i2c_data),
    .i2c_done(i2c_done), .i2c_status(i2c_status),
    .busy(busy), .done(done), .error(error),
    .fail_idx(fail_idx)
  );

  // Core model: logs each command, answers after lat cycles, holds done.
  always @(posedge clk) begin
    if (rst) begin
      cst = 0;
      cnt = 0;
      pos = 0;
      nacked_once = 0;
      log_q.delete();
      core_done   <= 1'b0;
      core_status <= 1'b0;
    end else begin
      case (cst)
        0: if (req && !i2c_done) begin
          if (i2c_start) begin
            log_q.push_back(10'h100);
            pos = 0;
            core_status <= 1'b0;
          end else if (i2c_stop) begin
            log_q.push_back(10'h200);
            core_status <= 1'b0;
          end else begin
            log_q.push_back({2'b00, i2c_data});
            nk = 0;
            if (mode == 2 && pos == 0) nk = 1;
            if (mode == 1 && pos == 1 && i2c_data == 8'h0C && !nacked_once) begin
              nk = 1;
              nacked_once = 1;
            end
            core_status <= nk;
            pos++;
          end
          cnt = lat;
          cst = 1;
        end
        1: if (cnt == 0) begin
          core_done <= 1'b1;
          cnt = hold;
          cst = 2;
        end else cnt--;
        2: if (!req) begin
          if (cnt == 0) begin
            core_done   <= 1'b0;
            core_status <= 1'b0;
            cst = 0;
          end else cnt--;
        end
        default: cst = 0;
      endcase
    end
  end

  // Protocol monitor on pre-edge values: one request at a time, none raised on stale done.
  always @(posedge clk) begin
    if (!rst) begin
      if ((32'(i2c_start) + 32'(i2c_write) + 32'(i2c_stop)) > 1) viol_multi++;
      if (req && !req_prev && done_prev) viol_stale++;
    end
    req_prev  = req;
    done_prev = i2c_done;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic apply_reset();
    @(negedge clk) rst = 1'b1;
    go = 1'b0;
    stale = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic pulse_go();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || error) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({i2c_start, i2c_write, i2c_stop} !== 3'b000) begin
      errors++;
      $display("FAIL reset_req got %b want 000", {i2c_start, i2c_write, i2c_stop});
    end
    checks++;
    if ({busy, done, error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status got %b want 000", {busy, done, error});
    end
    checks++;
    if ({i2c_data, tbl_idx, fail_idx} !== 10'h000) begin
      errors++;
      $display("FAIL reset_data got %h want 000", {i2c_data, tbl_idx, fail_idx});
    end
  endtask

  task automatic test_basic();
    logic [9:0] exp[$];
    bit ok;
    exp = '{10'h100, 10'h034, 10'h01E, 10'h000, 10'h200,
            10'h100, 10'h034, 10'h00C, 10'h012, 10'h200};
    mode = 0; lat = 2; hold = 0;
    apply_reset();
    pulse_go();
    checks++;
    if (busy !== 1'b1 || i2c_start !== 1'b0) begin
      errors++;
      $display("FAIL go_cycle1 got busy=%b start=%b want 1 0", busy, i2c_start);
    end
    @(negedge clk);
    checks++;
    if (i2c_start !== 1'b1) begin
      errors++;
      $display("FAIL go_cycle2 got start=%b want 1", i2c_start);
    end
    wait_end(1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got 0 want 1"); end
    checks++;
    if (log_q.size() != exp.size()) begin
      errors++;
      $display("FAIL basic_len got %0d want %0d", log_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_cmd[%0d] got %h want %h", i, log_q[i], exp[i]);
      end
    end
    checks++;
    if ({done, busy, error} !== 3'b100) begin
      errors++;
      $display("FAIL basic_end got %b want 100", {done, busy, error});
    end
  endtask

  task automatic test_retry_hi();
    logic [9:0] exp[$];
    bit ok;
`ifdef I2C_SEQ_RETRY_EN
    exp = '{10'h100, 10'h034, 10'h01E, 10'h000, 10'h200,
            10'h100, 10'h034, 10'h00C, 10'h200,
            10'h100, 10'h034, 10'h00C, 10'h012, 10'h200};
`else
    exp = '{10'h100, 10'h034, 10'h01E, 10'h000, 10'h200,
            10'h100, 10'h034, 10'h00C, 10'h200};
`endif
    mode = 1; lat = 1; hold = 0;
    apply_reset();
    pulse_go();
    wait_end(1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL retry_timeout got 0 want 1"); end
    checks++;
    if (log_q.size() != exp.size()) begin
      errors++;
      $display("FAIL retry_len got %0d want %0d", log_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL retry_cmd[%0d] got %h want %h", i, log_q[i], exp[i]);
      end
    end
    checks++;
`ifdef I2C_SEQ_RETRY_EN
    if ({done, error} !== 2'b10) begin
      errors++;
      $display("FAIL retry_end got %b want 10", {done, error});
    end
`else
    if ({done, error, fail_idx} !== 3'b011) begin
      errors++;
      $display("FAIL retry_end got %b want 011", {done, error, fail_idx});
    end
`endif
  endtask

  task automatic test_addr_nack();
    logic [9:0] exp[$];
    int n;
    bit ok;
`ifdef I2C_SEQ_RETRY_EN
    exp = '{10'h100, 10'h034, 10'h200, 10'h100, 10'h034, 10'h200,
            10'h100, 10'h034, 10'h200};
`else
    exp = '{10'h100, 10'h034, 10'h200};
`endif
    mode = 2; lat = 2; hold = 1;
    apply_reset();
    pulse_go();
    wait_end(1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nack_timeout got 0 want 1"); end
    checks++;
    if (log_q.size() != exp.size()) begin
      errors++;
      $display("FAIL nack_len got %0d want %0d", log_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL nack_cmd[%0d] got %h want %h", i, log_q[i], exp[i]);
      end
    end
    checks++;
    if ({error, done, busy, fail_idx} !== 4'b1000) begin
      errors++;
      $display("FAIL nack_end got %b want 1000", {error, done, busy, fail_idx});
    end
    n = log_q.size();
    repeat (20) @(negedge clk);
    checks++;
    if (log_q.size() != n || req !== 1'b0) begin
      errors++;
      $display("FAIL nack_quiet got len=%0d req=%b want %0d 0", log_q.size(), req, n);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp[$];
    bit ok;
    bit hit;
    exp = '{10'h100, 10'h034, 10'h01E, 10'h000, 10'h200,
            10'h100, 10'h034, 10'h00C, 10'h012, 10'h200};
    mode = 0; lat = 3; hold = 0;
    apply_reset();
    pulse_go();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (i2c_write && i2c_data == 8'h00) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_lo_seen got 0 want 1"); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({i2c_start, i2c_write, i2c_stop, busy, done, error} !== 6'b0 ||
        {i2c_data, tbl_idx, fail_idx} !== 10'h000) begin
      errors++;
      $display("FAIL mid_reset got %b %h want 000000 000",
               {i2c_start, i2c_write, i2c_stop, busy, done, error},
               {i2c_data, tbl_idx, fail_idx});
    end
    rst = 1'b0;
    pulse_go();
    wait_end(1000, ok);
    checks++;
    if (!ok || done !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart got ok=%0d done=%b want 1 1", ok, done);
    end
    checks++;
    if (log_q.size() != exp.size()) begin
      errors++;
      $display("FAIL mid_len got %0d want %0d", log_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL mid_cmd[%0d] got %h want %h", i, log_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_hold_stale();
    logic [9:0] exp[$];
    bit ok;
    exp = '{10'h100, 10'h034, 10'h01E, 10'h000, 10'h200,
            10'h100, 10'h034, 10'h00C, 10'h012, 10'h200};
    mode = 0; lat = 2; hold = 5;
    apply_reset();
    stale = 1'b1;
    pulse_go();
    repeat (5) @(negedge clk);
    checks++;
    if (i2c_start !== 1'b0) begin
      errors++;
      $display("FAIL stale_wait got start=%b want 0", i2c_start);
    end
    stale = 1'b0;
    @(negedge clk);
    checks++;
    if (i2c_start !== 1'b1) begin
      errors++;
      $display("FAIL stale_release got start=%b want 1", i2c_start);
    end
    repeat (30) @(negedge clk);
    pulse_go();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_go got busy=%b done=%b want 1 0", busy, done);
    end
    wait_end(3000, ok);
    checks++;
    if (!ok || done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL hold_end got ok=%0d done=%b err=%b want 1 1 0", ok, done, error);
    end
    checks++;
    if (log_q.size() != exp.size()) begin
      errors++;
      $display("FAIL hold_len got %0d want %0d", log_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL hold_cmd[%0d] got %h want %h", i, log_q[i], exp[i]);
      end
    end
    checks++;
    if (viol_stale != 0 || viol_multi != 0) begin
      errors++;
      $display("FAIL protocol got stale=%0d multi=%0d want 0 0", viol_stale, viol_multi);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retry_hi();
    test_addr_nack();
    test_reset_mid();
    test_hold_stale();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
